// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: decode offer, MEM/WB forwards, flush and the EX/ALU side.
// slave is the stage's view; master is the driver's view.
interface id_ex_operand_stage_if #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic                   id_ready;
  logic [3:0]             id_aluop;
  logic [REG_AW-1:0]      id_rs1;
  logic [REG_AW-1:0]      id_rs2;
  logic [DATA_W-1:0]      id_rs1_data;
  logic [DATA_W-1:0]      id_rs2_data;
  logic [DATA_W-1:0]      id_imm;
  logic                   id_use_imm;
  logic                   id_use_pc;
  logic [DATA_W-1:0]      id_pc;
  logic [REG_AW-1:0]      id_rd;
  logic                   id_regwrite;
  logic                   mem_fwd_valid;
  logic [REG_AW-1:0]      mem_fwd_rd;
  logic [DATA_W-1:0]      mem_fwd_data;
  logic                   wb_fwd_valid;
  logic [REG_AW-1:0]      wb_fwd_rd;
  logic [DATA_W-1:0]      wb_fwd_data;
  logic                   flush;
  logic                   ex_ready;
  logic                   ex_valid;
  logic [3:0]             aluop;
  logic [DATA_W-1:0]      porta;
  logic [DATA_W-1:0]      portb;
  logic [REG_AW-1:0]      ex_rd;
  logic                   ex_regwrite;
  logic [DATA_W-1:0]      ex_pc;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport slave (
    input  id_valid, id_aluop, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_use_pc, id_pc, id_rd, id_regwrite,
           mem_fwd_valid, mem_fwd_rd, mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
           flush, ex_ready,
    output id_ready, ex_valid, aluop, porta, portb, ex_rd, ex_regwrite, ex_pc, stall_cycles
  );

  modport master (
    output id_valid, id_aluop, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm,
           id_use_imm, id_use_pc, id_pc, id_rd, id_regwrite,
           mem_fwd_valid, mem_fwd_rd, mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data,
           flush, ex_ready,
    input  id_ready, ex_valid, aluop, porta, portb, ex_rd, ex_regwrite, ex_pc, stall_cycles
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// Registered ID/EX stage with MEM/WB operand forwarding; one cycle decode to ALU inputs.
// Backpressure: id_ready = ~flush & (~ex_valid | ex_ready); a held op keeps snooping forwards.
module id_ex_operand_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  id_ex_operand_stage_if.slave  bus
);

  logic                   ex_valid_q;
  logic [3:0]             aluop_q;
  logic [REG_AW-1:0]      rs1_q;
  logic [REG_AW-1:0]      rs2_q;
  logic [DATA_W-1:0]      rs1_val_q;
  logic [DATA_W-1:0]      rs2_val_q;
  logic [DATA_W-1:0]      imm_q;
  logic [DATA_W-1:0]      pc_q;
  logic [REG_AW-1:0]      rd_q;
  logic                   regwrite_q;
  logic                   use_imm_q;
  logic                   use_pc_q;
  logic [STALL_CNT_W-1:0] stall_q;

  logic                   id_ready;
  logic                   capture;
  logic                   stalled;
  logic [DATA_W-1:0]      cap_rs1_val;
  logic [DATA_W-1:0]      cap_rs2_val;
  logic [DATA_W-1:0]      snoop_rs1_val;
  logic [DATA_W-1:0]      snoop_rs2_val;

  // x0 is hardwired; MEM is younger than WB so it wins.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] fallback,
    input logic              mem_v,
    input logic [REG_AW-1:0] mem_rd,
    input logic [DATA_W-1:0] mem_d,
    input logic              wb_v,
    input logic [REG_AW-1:0] wb_rd,
    input logic [DATA_W-1:0] wb_d
  );
    logic [DATA_W-1:0] r;
    if (idx == '0)                    r = '0;
    else if (mem_v && mem_rd == idx)  r = mem_d;
    else if (wb_v && wb_rd == idx)    r = wb_d;
    else                              r = fallback;
    return r;
  endfunction

  always_comb begin
    id_ready      = ~bus.flush & (~ex_valid_q | bus.ex_ready);
    capture       = bus.id_valid & id_ready;
    stalled       = ex_valid_q & ~bus.ex_ready & ~bus.flush;
    cap_rs1_val   = resolve(bus.id_rs1, bus.id_rs1_data, bus.mem_fwd_valid, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    cap_rs2_val   = resolve(bus.id_rs2, bus.id_rs2_data, bus.mem_fwd_valid, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    snoop_rs1_val = resolve(rs1_q, rs1_val_q, bus.mem_fwd_valid, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
    snoop_rs2_val = resolve(rs2_q, rs2_val_q, bus.mem_fwd_valid, bus.mem_fwd_rd,
                            bus.mem_fwd_data, bus.wb_fwd_valid, bus.wb_fwd_rd, bus.wb_fwd_data);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ex_valid_q <= 1'b0;
      aluop_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      use_imm_q  <= 1'b0;
      use_pc_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      if (stalled && stall_q != '1)
        stall_q <= stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};

      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (capture) begin
        ex_valid_q <= 1'b1;
        aluop_q    <= bus.id_aluop;
        rs1_q      <= bus.id_rs1;
        rs2_q      <= bus.id_rs2;
        rs1_val_q  <= cap_rs1_val;
        rs2_val_q  <= cap_rs2_val;
        imm_q      <= bus.id_imm;
        pc_q       <= bus.id_pc;
        rd_q       <= bus.id_rd;
        regwrite_q <= bus.id_regwrite;
        use_imm_q  <= bus.id_use_imm;
        use_pc_q   <= bus.id_use_pc;
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end else if (ex_valid_q) begin
        // Producers retiring while we wait must still reach the held operands.
        rs1_val_q  <= snoop_rs1_val;
        rs2_val_q  <= snoop_rs2_val;
      end
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.aluop        = aluop_q;
  assign bus.porta        = use_pc_q  ? pc_q  : rs1_val_q;
  assign bus.portb        = use_imm_q ? imm_q : rs2_val_q;
  assign bus.ex_rd        = ex_valid_q ? rd_q : '0;
  assign bus.ex_regwrite  = regwrite_q & ex_valid_q;
  assign bus.ex_pc        = pc_q;
  assign bus.stall_cycles = stall_q;

endmodule
